// File: rtl/sap_clkctl.sv
// SAP clock-control stage: gates slow-clock edge pulses into paired CPU advance pulses
// according to run/step mode, a debounced step button and the CPU halt line.
module sap_clkctl #(
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic       i_sysclk,
  input  logic       i_reset_n,
  input  logic       i_clken,
  input  logic       i_clken2,
  input  logic       i_run_sw,
  input  logic       i_step_btn,
  input  logic       i_hlt,
  output logic       o_cpu_en,
  output logic       o_cpu_en2,
  output logic       o_halted,
  output logic [2:0] o_state
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRun      = 3'd1,
    StArmed    = 3'd2,
    StStepWait = 3'd3,
    StHalt     = 3'd4
  } state_e;

  // Index 0 carries run_sw, index 1 carries step_btn.
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_stable;
  logic [CntW-1:0] r_cnt [2];
  logic            r_btn_prev;
  logic            r_step_req;

  state_e          r_state;
  logic            r_cpu_en;
  logic            r_cpu_en2;
  logic            r_halted;

  state_e          w_state_d;
  logic            w_cpu_en_d;
  logic            w_cpu_en2_d;

  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync1 <= {i_step_btn, i_run_sw};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        // Counter only advances on slow ticks, and any agreement restarts the count.
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (i_clken) begin
          if (r_cnt[i] == CntMax) begin
            r_stable[i] <= r_sync2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CntW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_btn_prev <= 1'b0;
      r_step_req <= 1'b0;
    end else begin
      r_btn_prev <= r_stable[1];
      r_step_req <= r_stable[1] & ~r_btn_prev;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cpu_en_d  = 1'b0;
    w_cpu_en2_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_stable[0] && i_clken) begin
          w_cpu_en_d = 1'b1;
          w_state_d  = StRun;
        end else if (r_step_req) begin
          w_state_d = StArmed;
        end
      end
      StRun: begin
        // clken wins over a coincident clken2.
        if (i_clken) begin
          w_cpu_en_d = 1'b1;
        end else if (i_clken2) begin
          w_cpu_en2_d = 1'b1;
          if (i_hlt) begin
            w_state_d = StHalt;
          end else if (!r_stable[0]) begin
            w_state_d = StIdle;
          end
        end
      end
      StArmed: begin
        if (i_clken) begin
          w_cpu_en_d = 1'b1;
          w_state_d  = StStepWait;
        end
      end
      StStepWait: begin
        if (i_clken2 && !i_clken) begin
          w_cpu_en2_d = 1'b1;
          w_state_d   = i_hlt ? StHalt : StIdle;
        end
      end
      StHalt: begin
        w_state_d = StHalt;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= StIdle;
      r_cpu_en  <= 1'b0;
      r_cpu_en2 <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cpu_en  <= w_cpu_en_d;
      r_cpu_en2 <= w_cpu_en2_d;
      r_halted  <= (w_state_d == StHalt);
    end
  end

  assign o_cpu_en  = r_cpu_en;
  assign o_cpu_en2 = r_cpu_en2;
  assign o_halted  = r_halted;
  assign o_state   = r_state;

endmodule

// File: tb/tb_sap_clkctl.sv
// Self-checking bench for sap_clkctl: DIVISOR=10 edge pulses, randomized timing,
// per-cycle comparison against a behavioural model plus scenario-level pulse counts.
module tb_sap_clkctl;

  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clken = 1'b0;
  logic       clken2 = 1'b0;
  logic       run_sw = 1'b0;
  logic       step_btn = 1'b0;
  logic       hlt = 1'b0;
  logic       cpu_en;
  logic       cpu_en2;
  logic       halted;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sap_clkctl #(.DEBOUNCE_TICKS(DT)) dut (
    .i_sysclk  (clk),
    .i_reset_n (rst_n),
    .i_clken   (clken),
    .i_clken2  (clken2),
    .i_run_sw  (run_sw),
    .i_step_btn(step_btn),
    .i_hlt     (hlt),
    .o_cpu_en  (cpu_en),
    .o_cpu_en2 (cpu_en2),
    .o_halted  (halted),
    .o_state   (state)
  );

  // Slow-clock generator: clken at 10k+9, clken2 at 10k+4.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      clken  = (cyc % 10 == 9);
      clken2 = (cyc % 10 == 4);
    end
  end

  // Behavioural reference: states numbered as IDLE=0 RUN=1 ARMED=2 STEP_WAIT=3 HALT=4.
  typedef struct {
    bit [1:0] run_hist;
    bit [1:0] btn_hist;
    bit       run_st;
    bit       btn_st;
    int       run_ticks;
    int       btn_ticks;
    bit       btn_prev;
    bit       step_req;
    int       st;
    bit       en;
    bit       en2;
  } mdl_t;

  mdl_t m;
  mdl_t m_zero;

  function automatic mdl_t nxt(input mdl_t c);
    mdl_t n = c;
    n.run_hist = {c.run_hist[0], run_sw};
    n.btn_hist = {c.btn_hist[0], step_btn};
    if (c.run_hist[1] == c.run_st) n.run_ticks = 0;
    else if (clken) begin
      if (c.run_ticks + 1 == DT) begin
        n.run_st = c.run_hist[1];
        n.run_ticks = 0;
      end else n.run_ticks = c.run_ticks + 1;
    end
    if (c.btn_hist[1] == c.btn_st) n.btn_ticks = 0;
    else if (clken) begin
      if (c.btn_ticks + 1 == DT) begin
        n.btn_st = c.btn_hist[1];
        n.btn_ticks = 0;
      end else n.btn_ticks = c.btn_ticks + 1;
    end
    n.step_req = c.btn_st && !c.btn_prev;
    n.btn_prev = c.btn_st;
    n.en = 1'b0;
    n.en2 = 1'b0;
    if (c.st == 0) begin
      if (c.run_st && clken) begin n.en = 1'b1; n.st = 1; end
      else if (c.step_req) n.st = 2;
    end else if (c.st == 1) begin
      if (clken) n.en = 1'b1;
      else if (clken2) begin
        n.en2 = 1'b1;
        n.st = hlt ? 4 : (c.run_st ? 1 : 0);
      end
    end else if (c.st == 2) begin
      if (clken) begin n.en = 1'b1; n.st = 3; end
    end else if (c.st == 3) begin
      if (clken2 && !clken) begin n.en2 = 1'b1; n.st = hlt ? 4 : 0; end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_zero;
    else m <= nxt(m);
  end

  task automatic test_reset();
    rst_n = 1'b0; run_sw = 1'b0; step_btn = 1'b0; hlt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cpu_en, cpu_en2, halted, state} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=000000", {cpu_en, cpu_en2, halted, state});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({cpu_en, cpu_en2, halted, state} !== {m.en, m.en2, m.st == 4, 3'(m.st)}) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b%b%b st=%0d want=%b%b st=%0d",
                 cyc, cpu_en, cpu_en2, halted, state, m.en, m.en2, m.st);
      end
    end
  endtask

  task automatic test_run();
    int last_en = -1;
    int n_en = 0;
    int n_en2 = 0;
    @(posedge clk); #1 run_sw = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if ({cpu_en, cpu_en2, halted, state} !== {m.en, m.en2, m.st == 4, 3'(m.st)}) begin
        failures++;
        $display("FAIL run_model cyc=%0d got=%b%b%b st=%0d want=%b%b st=%0d",
                 cyc, cpu_en, cpu_en2, halted, state, m.en, m.en2, m.st);
      end
      if (cpu_en) begin
        n_en++;
        checks++;
        if (cyc % 10 != 0 || (last_en >= 0 && cyc - last_en != 10)) begin
          failures++;
          $display("FAIL run_en_period cyc=%0d last_en=%0d want period 10", cyc, last_en);
        end
        last_en = cyc;
      end
      if (cpu_en2) begin
        n_en2++;
        checks++;
        if (last_en < 0 || cyc - last_en != 5) begin
          failures++;
          $display("FAIL run_en2_offset cyc=%0d last_en=%0d want offset 5", cyc, last_en);
        end
      end
    end
    checks++;
    if (state !== 3'd1 || n_en < 14 || n_en2 > n_en || n_en - n_en2 > 1) begin
      failures++;
      $display("FAIL run_summary state=%0d en=%0d en2=%0d want state=1 en>=14 paired",
               state, n_en, n_en2);
    end
  endtask

  task automatic test_run_exit();
    bit seen = 1'b0;
    int n_en = 0;
    int n_en2 = 0;
    int late = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (cpu_en) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL run_exit_timeout got=no cpu_en want=cpu_en within 30 cycles");
    end
    @(posedge clk); #1 run_sw = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      checks++;
      if ({cpu_en, cpu_en2, halted, state} !== {m.en, m.en2, m.st == 4, 3'(m.st)}) begin
        failures++;
        $display("FAIL run_exit_model cyc=%0d got=%b%b%b st=%0d want=%b%b st=%0d",
                 cyc, cpu_en, cpu_en2, halted, state, m.en, m.en2, m.st);
      end
      n_en += int'(cpu_en);
      n_en2 += int'(cpu_en2);
      if (i >= 80) late += int'(cpu_en) + int'(cpu_en2);
    end
    checks++;
    if (n_en2 != n_en + 1 || state !== 3'd0 || late != 0) begin
      failures++;
      $display("FAIL run_exit_pairing en=%0d en2=%0d late=%0d state=%0d want en2=en+1 idle",
               n_en, n_en2, late, state);
    end
  endtask

  // Shared by plain and bouncing presses: pattern 0 = clean hold, 1 = bounce first.
  task automatic test_step(input bit bounce);
    int n_en = 0;
    int n_en2 = 0;
    int late = 0;
    int seq[$];
    logic [2:0] prev = 3'd0;
    int pre = $urandom_range(0, 9);
    repeat (pre) @(posedge clk);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bounce && i < 25) step_btn = ((i / 3) % 2 == 0);
      else step_btn = (i < 130);
      @(negedge clk);
      checks++;
      if ({cpu_en, cpu_en2, halted, state} !== {m.en, m.en2, m.st == 4, 3'(m.st)}) begin
        failures++;
        $display("FAIL step_model b=%0d cyc=%0d got=%b%b%b st=%0d want=%b%b st=%0d",
                 bounce, cyc, cpu_en, cpu_en2, halted, state, m.en, m.en2, m.st);
      end
      n_en += int'(cpu_en);
      n_en2 += int'(cpu_en2);
      if (i >= 90) late += int'(cpu_en) + int'(cpu_en2);
      if (state !== prev) begin
        seq.push_back(int'(state));
        prev = state;
      end
    end
    checks++;
    if (n_en != 1 || n_en2 != 1 || late != 0) begin
      failures++;
      $display("FAIL step_count b=%0d en=%0d en2=%0d late=%0d want 1 1 0",
               bounce, n_en, n_en2, late);
    end
    checks++;
    if (seq.size() != 3 || seq[0] != 2 || seq[1] != 3 || seq[2] != 0) begin
      failures++;
      $display("FAIL step_seq b=%0d got size=%0d want 2,3,0", bounce, seq.size());
    end
  endtask

  task automatic test_halt();
    bit seen = 1'b0;
    int n_en = 0;
    int n_en2 = 0;
    int k = $urandom_range(1, 3);
    @(posedge clk); #1 run_sw = 1'b1;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(negedge clk);
      if (cpu_en && state === 3'd1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL halt_timeout got=no cpu_en want=cpu_en in RUN within 120 cycles");
    end
    for (int i = 0; i < 130; i++) begin
      @(posedge clk);
      #1;
      if (i == k - 1) hlt = 1'b1;
      if (i >= 10 && i % 7 == 0) run_sw = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({cpu_en, cpu_en2, halted, state} !== {m.en, m.en2, m.st == 4, 3'(m.st)}) begin
        failures++;
        $display("FAIL halt_model cyc=%0d got=%b%b%b st=%0d want=%b%b st=%0d",
                 cyc, cpu_en, cpu_en2, halted, state, m.en, m.en2, m.st);
      end
      n_en += int'(cpu_en);
      n_en2 += int'(cpu_en2);
    end
    checks++;
    if (n_en != 0 || n_en2 != 1 || state !== 3'd4 || halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_summary en=%0d en2=%0d state=%0d halted=%b want 0 1 4 1",
               n_en, n_en2, state, halted);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_reset state=%0d halted=%b want 0 0", state, halted);
    end
    hlt = 1'b0; run_sw = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset_stepwait();
    bit seen = 1'b0;
    int n_pulse = 0;
    repeat ($urandom_range(0, 9)) @(posedge clk);
    #1 step_btn = 1'b1;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(negedge clk);
      checks++;
      if ({cpu_en, cpu_en2, halted, state} !== {m.en, m.en2, m.st == 4, 3'(m.st)}) begin
        failures++;
        $display("FAIL rsw_model cyc=%0d got=%b%b%b st=%0d want=%b%b st=%0d",
                 cyc, cpu_en, cpu_en2, halted, state, m.en, m.en2, m.st);
      end
      if (cpu_en) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rsw_timeout got=no cpu_en want=cpu_en within 120 cycles");
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    step_btn = 1'b0;
    #1;
    checks++;
    if ({cpu_en, cpu_en2, halted, state} !== 6'b0) begin
      failures++;
      $display("FAIL rsw_immediate got=%b want=000000", {cpu_en, cpu_en2, halted, state});
    end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) rst_n = 1'b1;
      @(negedge clk);
      n_pulse += int'(cpu_en) + int'(cpu_en2);
    end
    checks++;
    if (n_pulse != 0 || state !== 3'd0) begin
      failures++;
      $display("FAIL rsw_after pulses=%0d state=%0d want 0 0", n_pulse, state);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_run_exit();
    test_step(1'b0);
    test_step(1'b1);
    test_halt();
    test_reset_stepwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
